fifo_arb_ctrl: RTL

Two-client arbiter and sequencer for the 8-entry FIFO.
- Accepts read/write requests from two clients, picks one round-robin and issues a single-cycle rd_en/wr_en to the FIFO.
- Captures read data and returns a done/err response to the granted client.
- Blocks FIFO overflow/underflow at the controller level: an illegal op produces err instead of a FIFO access.

---
 rtl/fifo_arb_ctrl_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 19 +
 rtl/fifo_arb_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fifo_arb_ctrl_pkg.sv
// Shared definitions for the two-client FIFO arbiter/controller and the FIFO it drives.
package fifo_arb_ctrl_pkg;

  // Controller state encoding; the values are fixed so traces line up with the FIFO side.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StIssue  = 2'b01,
    StWaitRd = 2'b10,
    StResp   = 2'b11
  } ctrl_state_e;

  // Per-client op encoding
  localparam logic OpRead  = 1'b0;
  localparam logic OpWrite = 1'b1;

  // FIFO-side state constants, kept here so the controller and FIFO agree on names/values
  typedef enum logic [2:0] {
    FifoInit    = 3'd0,
    FifoRead    = 3'd1,
    FifoWrite   = 3'd2,
    FifoRdError = 3'd3,
    FifoWrError = 3'd4,
    FifoNoOp    = 3'd5
  } fifo_state_e;

  // Client index to one-hot grant/done vector
  function automatic logic [1:0] client_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker: the client that did not win last goes first on a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       sel_o
);

  // Single requester wins outright; on a tie the client other than last wins
  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b10:   sel_o = 1'b1;
      2'b11:   sel_o = ~last_i;
      default: sel_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Two-client arbiter and sequencer for an 8-entry FIFO. One transaction at a time; illegal
// ops (write when full, read when empty) are answered with err instead of a FIFO access.
module fifo_arb_ctrl
  import fifo_arb_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            done_o,
  output logic [1:0]            err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  fifo_full_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  output logic                  fifo_wr_en_o,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] fifo_din_o,
  output logic                  busy_o
);

  // Counter preload so that fifo_dout is captured RD_LAT cycles after the read strobe
  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

  ctrl_state_e           state_q, state_d;
  logic                  last_q, last_d;
  logic                  sel_q, sel_d;
  logic                  op_q, op_d;
  logic                  err_q, err_d;
  logic [1:0]            lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic arb_valid;
  logic arb_sel;
  logic wr_ok;
  logic rd_ok;

  rr_arb2 u_arb (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (arb_valid),
    .sel_o   (arb_sel)
  );

  // Legality of the latched op against the live FIFO flags; only consulted in StIssue
  assign wr_ok = (op_q == OpWrite) && !fifo_full_i;
  assign rd_ok = (op_q == OpRead) && !fifo_empty_i;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      lat_cnt_q <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      op_q      <= op_d;
      err_q     <= err_d;
      lat_cnt_q <= lat_cnt_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    op_d      = op_q;
    err_d     = err_q;
    lat_cnt_d = lat_cnt_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          sel_d   = arb_sel;
          op_d    = op_i[arb_sel];
          data_d  = arb_sel ? wdata1_i : wdata0_i;
          err_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (wr_ok) begin
          state_d = StResp;
        end else if (rd_ok) begin
          lat_cnt_d = LatInit;
          state_d   = StWaitRd;
        end else begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StWaitRd: begin
        if (lat_cnt_q == 2'd0) begin
          rdata_d = fifo_dout_i;
          state_d = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      StResp: begin
        // Errors also count as a turn, so the other client gets the next tie
        last_d  = sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; strobes only ever fire in StIssue
  always_comb begin
    gnt_o        = 2'b00;
    done_o       = 2'b00;
    err_o        = 2'b00;
    fifo_wr_en_o = 1'b0;
    fifo_rd_en_o = 1'b0;
    case (state_q)
      StIssue: begin
        gnt_o        = client_onehot(sel_q);
        fifo_wr_en_o = wr_ok;
        fifo_rd_en_o = rd_ok;
      end
      StResp: begin
        done_o = client_onehot(sel_q);
        err_o  = err_q ? client_onehot(sel_q) : 2'b00;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != StIdle);
  assign fifo_din_o = data_q;
  assign rdata_o    = rdata_q;

endmodule
